alu_arbiter: RTL

- Shares one registered 64-bit ALU between NREQ requesters. Each requester supplies an opcode and two operands.
- Picks one requester per cycle with a round-robin arbiter and drives the ALU operand/opcode inputs.
- Tracks in-flight operations through the ALU's fixed latency and buffers results in a credit-guarded response FIFO.
- Sits between the issue/dispatch logic and the shared ALU; results are returned tagged with the requester index.

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one registered 64-bit ALU between NREQ requesters. A round-robin
// arbiter picks at most one requester per cycle and drives its opcode and
// operands onto the ALU inputs. A small valid+tag pipeline follows each
// operation through the ALU latency. When the result appears, it is written
// into a response FIFO together with the requester tag. Issue is
// credit-guarded so that the FIFO can never overflow.
//
// Ports:
//   clk             clock, all state updates on posedge
//   rst             synchronous active-high reset
//   req_valid       per-requester request valid            [NREQ]
//   req_op          packed opcodes, requester i at [5i+4:5i]
//   req_a, req_b    packed 64-bit operands, requester i at [64i+63:64i]
//   req_ready       one-hot-or-zero grant                   [NREQ]
//   alu_instruction opcode to the ALU (5'd31 when idle)
//   alu_a, alu_b    operands to the ALU (0 when idle)
//   alu_result      registered ALU result
//   rsp_valid       response FIFO non-empty
//   rsp_ready       consumer accepts the head response
//   rsp_data        result at the FIFO head (0 when empty)
//   rsp_id          requester tag at the FIFO head (0 when empty)
//   busy            an op is in flight or the FIFO holds a result
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NREQ       = 4,
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_op,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [4:0]           alu_instruction,
  output logic [63:0]          alu_a,
  output logic [63:0]          alu_b,
  input  logic [63:0]          alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int INFW = $clog2(ALU_LAT + 2);

  // Arbitration state: index of the most recently granted requester.
  logic [IDW-1:0]  last;

  // In-flight tracking. Stage 0 holds the op granted in the previous cycle.
  // The last stage holds the op whose result is on alu_result this cycle.
  logic [ALU_LAT-1:0] pv;
  logic [IDW-1:0]     pt [ALU_LAT];

  // Response FIFO.
  logic [63:0]     mem    [FIFO_DEPTH];
  logic [IDW-1:0]  mem_id [FIFO_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   fifo_count;

  logic [INFW-1:0] inflight_count;
  logic            issue_ok;
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic            grant;
  logic            push;
  logic            pop;

  always_comb begin
    inflight_count = '0;
    for (int j = 0; j < ALU_LAT; j++) begin
      inflight_count = inflight_count + INFW'(pv[j]);
    end
  end

  // Credit is based only on registered counts. A pop this cycle therefore
  // frees its slot one cycle later. The op granted this cycle appears in
  // inflight_count from the next cycle on. Because at most one op is
  // granted per cycle, the FIFO cannot overflow.
  assign issue_ok = (int'(fifo_count) + int'(inflight_count)) < FIFO_DEPTH;

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(last) + off) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A grant always coincides with a transfer, because only valid requesters
  // are candidates.
  assign grant = !rst && issue_ok && grant_found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    alu_instruction = 5'd31;
    alu_a           = '0;
    alu_b           = '0;
    if (grant) begin
      alu_instruction = req_op[int'(grant_idx)*5 +: 5];
      alu_a           = req_a[int'(grant_idx)*64 +: 64];
      alu_b           = req_b[int'(grant_idx)*64 +: 64];
    end
  end

  assign push      = pv[ALU_LAT-1];
  assign rsp_valid = !rst && (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = (fifo_count != '0) ? mem[rptr]    : '0;
  assign rsp_id    = (fifo_count != '0) ? mem_id[rptr] : '0;
  assign busy      = !rst && ((fifo_count != '0) || (|pv));

  // Control state: arbitration pointer, tracking pipeline, FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= IDW'(NREQ - 1);
      pv         <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      for (int j = 0; j < ALU_LAT; j++) begin
        pt[j] <= '0;
      end
    end else begin
      if (grant) begin
        last <= grant_idx;
      end
      pv[0] <= grant;
      pt[0] <= grant_idx;
      for (int j = 1; j < ALU_LAT; j++) begin
        pv[j] <= pv[j-1];
        pt[j] <= pt[j-1];
      end
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  // FIFO storage needs no reset. Entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr]    <= alu_result;
      mem_id[wptr] <= pt[ALU_LAT-1];
    end
  end

endmodule
